// File: rtl/csr_file_if.sv
// rtl/csr_file_if.sv - CSR request/response bundle between the core pipeline and csr_file
interface csr_file_if;
    logic [11:0] readAddr;
    logic        readEnable;
    logic [31:0] readValue;
    logic        readIllegal;
    logic [11:0] writeAddr;
    logic [31:0] writeValue;
    logic        writeEnable;
    logic        trapValid;
    logic        trapInterrupt;
    logic [3:0]  trapCause;
    logic [31:0] trapValue;
    logic [31:0] trapPc;
    logic        trapReturn;
    logic [1:0]  trapReturnPrivilege;
    logic [31:0] nextPc;
    logic [31:0] satp;
    logic [31:0] mstatus;
    logic [1:0]  privilege;
    logic        trapSupervisorReturn;

    modport master (
        output readAddr, readEnable, writeAddr, writeValue, writeEnable,
               trapValid, trapInterrupt, trapCause, trapValue, trapPc,
               trapReturn, trapReturnPrivilege,
        input  readValue, readIllegal, nextPc, satp, mstatus, privilege,
               trapSupervisorReturn
    );

    modport slave (
        input  readAddr, readEnable, writeAddr, writeValue, writeEnable,
               trapValid, trapInterrupt, trapCause, trapValue, trapPc,
               trapReturn, trapReturnPrivilege,
        output readValue, readIllegal, nextPc, satp, mstatus, privilege,
               trapSupervisorReturn
    );
endinterface

// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine/supervisor CSR state, privilege, trap entry/return and cycle counter
module csr_file #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          XLEN     = 32
) (
    input  logic       clk,
    input  logic       rstN,
    csr_file_if.slave  bus
);
    localparam logic [31:0] M_MASK = 32'h005C_19AA;
    localparam logic [31:0] S_MASK = 32'h000C_0122;
    localparam logic [31:0] MISA   = 32'h4014_0100;

    logic [XLEN-1:0] r_mstatus, r_mtvec, r_medeleg, r_mideleg, r_mscratch, r_mepc, r_mcause, r_mtval;
    logic [XLEN-1:0] r_stvec, r_sscratch, r_sepc, r_scause, r_stval, r_satp;
    logic [XLEN-1:0] r_next_pc;
    logic [63:0]     r_cycle;
    logic [1:0]      r_priv;

    logic [31:0] w_rd_val;
    logic        w_rd_impl;
    logic        w_rd_illegal;

    always_comb begin
        w_rd_val  = '0;
        w_rd_impl = 1'b1;
        case (bus.readAddr)
            12'h100: w_rd_val = r_mstatus & S_MASK;
            12'h105: w_rd_val = r_stvec;
            12'h140: w_rd_val = r_sscratch;
            12'h141: w_rd_val = r_sepc;
            12'h142: w_rd_val = r_scause;
            12'h143: w_rd_val = r_stval;
            12'h180: w_rd_val = r_satp;
            12'h300: w_rd_val = r_mstatus;
            12'h301: w_rd_val = MISA;
            12'h302: w_rd_val = r_medeleg;
            12'h303: w_rd_val = r_mideleg;
            12'h305: w_rd_val = r_mtvec;
            12'h340: w_rd_val = r_mscratch;
            12'h341: w_rd_val = r_mepc;
            12'h342: w_rd_val = r_mcause;
            12'h343: w_rd_val = r_mtval;
            12'hB00, 12'hC00: w_rd_val = r_cycle[31:0];
            12'hB80, 12'hC80: w_rd_val = r_cycle[63:32];
            12'hF14: w_rd_val = '0;
            default: w_rd_impl = 1'b0;
        endcase
    end

    // CSR address bits [9:8] encode the lowest privilege allowed to access it
    assign w_rd_illegal    = bus.readEnable && (!w_rd_impl || (bus.readAddr[9:8] > r_priv));
    assign bus.readIllegal = w_rd_illegal;
    assign bus.readValue   = w_rd_illegal ? '0 : w_rd_val;

    logic [31:0] w_deleg;
    logic        w_to_s;
    logic [31:0] w_tvec;
    logic [31:0] w_trap_target;
    logic [31:0] w_trap_cause;
    logic [31:0] w_mst_wr;
    logic [31:0] w_sst_wr;
    logic [31:0] w_wr_aligned;

    assign w_deleg       = bus.trapInterrupt ? r_mideleg : r_medeleg;
    assign w_to_s        = (r_priv != 2'b11) && w_deleg[bus.trapCause];
    assign w_tvec        = w_to_s ? r_stvec : r_mtvec;
    assign w_trap_target = {w_tvec[31:2], 2'b00} +
                           ((w_tvec[1:0] == 2'b01 && bus.trapInterrupt) ? {26'b0, bus.trapCause, 2'b00} : 32'b0);
    assign w_trap_cause  = {bus.trapInterrupt, 27'b0, bus.trapCause};
    assign w_sst_wr      = (r_mstatus & ~S_MASK) | (bus.writeValue & S_MASK);
    assign w_wr_aligned  = {bus.writeValue[31:2], 2'b00};

    // MPP=10 is a reserved encoding and collapses to U
    always_comb begin
        w_mst_wr = bus.writeValue & M_MASK;
        if (w_mst_wr[12:11] == 2'b10) w_mst_wr[12:11] = 2'b00;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_mstatus  <= '0; r_mtvec    <= '0; r_medeleg <= '0; r_mideleg <= '0;
            r_mscratch <= '0; r_mepc     <= '0; r_mcause  <= '0; r_mtval   <= '0;
            r_stvec    <= '0; r_sscratch <= '0; r_sepc    <= '0; r_scause  <= '0;
            r_stval    <= '0; r_satp     <= '0;
            r_cycle    <= '0;
            r_priv     <= 2'b11;
            r_next_pc  <= RESET_PC;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            if (bus.trapValid) begin
                r_next_pc <= w_trap_target;
                if (w_to_s) begin
                    r_sepc       <= bus.trapPc;
                    r_scause     <= w_trap_cause;
                    r_stval      <= bus.trapValue;
                    r_mstatus[5] <= r_mstatus[1];
                    r_mstatus[1] <= 1'b0;
                    r_mstatus[8] <= r_priv[0];
                    r_priv       <= 2'b01;
                end else begin
                    r_mepc             <= bus.trapPc;
                    r_mcause           <= w_trap_cause;
                    r_mtval            <= bus.trapValue;
                    r_mstatus[7]       <= r_mstatus[3];
                    r_mstatus[3]       <= 1'b0;
                    r_mstatus[12:11]   <= r_priv;
                    r_priv             <= 2'b11;
                end
            end else if (bus.trapReturn) begin
                if (bus.trapReturnPrivilege == 2'b11) begin
                    r_priv           <= r_mstatus[12:11];
                    r_mstatus[3]     <= r_mstatus[7];
                    r_mstatus[7]     <= 1'b1;
                    r_mstatus[12:11] <= 2'b00;
                    r_next_pc        <= r_mepc;
                end else if (bus.trapReturnPrivilege == 2'b01) begin
                    r_priv       <= {1'b0, r_mstatus[8]};
                    r_mstatus[1] <= r_mstatus[5];
                    r_mstatus[5] <= 1'b1;
                    r_mstatus[8] <= 1'b0;
                    r_next_pc    <= r_sepc;
                end
            end else if (bus.writeEnable) begin
                case (bus.writeAddr)
                    12'h100: r_mstatus  <= w_sst_wr;
                    12'h105: r_stvec    <= w_wr_aligned;
                    12'h140: r_sscratch <= bus.writeValue;
                    12'h141: r_sepc     <= w_wr_aligned;
                    12'h142: r_scause   <= bus.writeValue;
                    12'h143: r_stval    <= bus.writeValue;
                    12'h180: r_satp     <= bus.writeValue;
                    12'h300: r_mstatus  <= w_mst_wr;
                    12'h302: r_medeleg  <= bus.writeValue;
                    12'h303: r_mideleg  <= bus.writeValue;
                    12'h305: r_mtvec    <= w_wr_aligned;
                    12'h340: r_mscratch <= bus.writeValue;
                    12'h341: r_mepc     <= w_wr_aligned;
                    12'h342: r_mcause   <= bus.writeValue;
                    12'h343: r_mtval    <= bus.writeValue;
                    12'hB00: r_cycle    <= {r_cycle[63:32], bus.writeValue};
                    12'hB80: r_cycle    <= {bus.writeValue, r_cycle[31:0]};
                    default: ;
                endcase
            end
        end
    end

    assign bus.nextPc               = r_next_pc;
    assign bus.satp                 = r_satp;
    assign bus.mstatus              = r_mstatus;
    assign bus.privilege            = r_priv;
    assign bus.trapSupervisorReturn = r_mstatus[22];
endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - directed plus randomized checks of csr_file against a field-level model
module tb_csr_file;
    logic clk  = 1'b0;
    logic rstN = 1'b0;

    csr_file_if bus();

    csr_file #(.RESET_PC(32'h8000_0000), .XLEN(32)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bit [1:0]        m_priv;
    bit [31:0]       m_npc;
    bit              m_sie, m_mie, m_spie, m_mpie, m_spp, m_sum, m_mxr, m_tvm, m_tsr;
    bit [1:0]        m_mpp;
    bit [31:0]       m_csr [int];
    longint unsigned m_cycle;

    function automatic void model_reset();
        int keys [15] = '{'h105, 'h140, 'h141, 'h142, 'h143, 'h180, 'h302, 'h303,
                          'h305, 'h340, 'h341, 'h342, 'h343, 'h7FF, 'h7FE};
        m_priv = 2'b11;
        m_npc  = 32'h8000_0000;
        {m_sie, m_mie, m_spie, m_mpie, m_spp, m_sum, m_mxr, m_tvm, m_tsr} = '0;
        m_mpp   = 2'b00;
        m_cycle = 0;
        m_csr.delete();
        for (int i = 0; i < 13; i++) m_csr[keys[i]] = 32'h0;
    endfunction

    function automatic bit [31:0] m_mstatus();
        return {9'b0, m_tsr, 1'b0, m_tvm, m_mxr, m_sum, 5'b0, m_mpp, 2'b0,
                m_spp, m_mpie, 1'b0, m_spie, 1'b0, m_mie, 1'b0, m_sie, 1'b0};
    endfunction

    function automatic bit [31:0] m_sstatus();
        return {12'b0, m_mxr, m_sum, 9'b0, m_spp, 2'b0, m_spie, 3'b0, m_sie, 1'b0};
    endfunction

    function automatic void model_read(input bit [11:0] a, input bit en,
                                       output bit [31:0] v, output bit ill);
        bit impl = 1'b1;
        v = 32'h0;
        case (a)
            12'h100: v = m_sstatus();
            12'h300: v = m_mstatus();
            12'h301: v = 32'h4014_0100;
            12'hF14: v = 32'h0;
            12'hB00, 12'hC00: v = 32'(m_cycle % 64'h1_0000_0000);
            12'hB80, 12'hC80: v = 32'(m_cycle / 64'h1_0000_0000);
            default: if (m_csr.exists(int'(a))) v = m_csr[int'(a)]; else impl = 1'b0;
        endcase
        ill = en && (!impl || (a[9:8] > m_priv));
        if (ill) v = 32'h0;
    endfunction

    function automatic void model_write(input bit [11:0] a, input bit [31:0] d, output bit cyc_wr);
        cyc_wr = 1'b0;
        if (a[11:10] == 2'b11) return;
        case (a)
            12'h300: begin
                m_sie = d[1]; m_mie = d[3]; m_spie = d[5]; m_mpie = d[7]; m_spp = d[8];
                m_mpp = (d[12:11] == 2'b10) ? 2'b00 : d[12:11];
                m_sum = d[18]; m_mxr = d[19]; m_tvm = d[20]; m_tsr = d[22];
            end
            12'h100: begin
                m_sie = d[1]; m_spie = d[5]; m_spp = d[8]; m_sum = d[18]; m_mxr = d[19];
            end
            12'h105, 12'h305, 12'h141, 12'h341: m_csr[int'(a)] = d & ~32'h3;
            12'hB00: begin
                m_cycle = (m_cycle & 64'hFFFF_FFFF_0000_0000) | 64'(d);
                cyc_wr  = 1'b1;
            end
            12'hB80: begin
                m_cycle = (m_cycle & 64'h0000_0000_FFFF_FFFF) | (64'(d) << 32);
                cyc_wr  = 1'b1;
            end
            default: if (m_csr.exists(int'(a))) m_csr[int'(a)] = d;
        endcase
    endfunction

    function automatic void model_step();
        bit        cyc_wr = 1'b0;
        int        c;
        bit        intr;
        bit [31:0] dl, tv, cz;
        if (bus.trapValid) begin
            c    = int'(bus.trapCause);
            intr = bus.trapInterrupt;
            dl   = intr ? m_csr['h303] : m_csr['h302];
            cz   = {intr, 27'b0, bus.trapCause};
            if (m_priv != 2'b11 && dl[c]) begin
                m_csr['h141] = bus.trapPc; m_csr['h142] = cz; m_csr['h143] = bus.trapValue;
                m_spie = m_sie; m_sie = 1'b0; m_spp = m_priv[0]; m_priv = 2'b01;
                tv = m_csr['h105];
            end else begin
                m_csr['h341] = bus.trapPc; m_csr['h342] = cz; m_csr['h343] = bus.trapValue;
                m_mpie = m_mie; m_mie = 1'b0; m_mpp = m_priv; m_priv = 2'b11;
                tv = m_csr['h305];
            end
            m_npc = (tv & ~32'h3) + (((tv % 4) == 1 && intr) ? 32'(4 * c) : 32'h0);
        end else if (bus.trapReturn) begin
            if (bus.trapReturnPrivilege == 2'b11) begin
                m_priv = m_mpp; m_mie = m_mpie; m_mpie = 1'b1; m_mpp = 2'b00;
                m_npc  = m_csr['h341];
            end else if (bus.trapReturnPrivilege == 2'b01) begin
                m_priv = {1'b0, m_spp}; m_sie = m_spie; m_spie = 1'b1; m_spp = 1'b0;
                m_npc  = m_csr['h141];
            end
        end else if (bus.writeEnable) begin
            model_write(bus.writeAddr, bus.writeValue, cyc_wr);
        end
        if (!cyc_wr) m_cycle = m_cycle + 1;
    endfunction

    always @(posedge clk or negedge rstN) begin
        if (!rstN) model_reset();
        else       model_step();
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_priv"},    32'(bus.privilege),            32'(m_priv));
        chk({tag, "_npc"},     bus.nextPc,                    m_npc);
        chk({tag, "_mstatus"}, bus.mstatus,                   m_mstatus());
        chk({tag, "_satp"},    bus.satp,                      m_csr['h180]);
        chk({tag, "_tsr"},     32'(bus.trapSupervisorReturn), 32'(m_tsr));
    endtask

    task automatic check_read(input string tag, input bit [11:0] a, input bit en);
        bit [31:0] v;
        bit        ill;
        bus.readAddr   = a;
        bus.readEnable = en;
        #1;
        model_read(a, en, v, ill);
        chk({tag, "_rdval"}, bus.readValue,          v);
        chk({tag, "_rdill"}, 32'(bus.readIllegal),   32'(ill));
    endtask

    task automatic idle_inputs();
        bus.writeEnable = 1'b0; bus.writeAddr  = 12'h0;  bus.writeValue = 32'h0;
        bus.trapValid   = 1'b0; bus.trapInterrupt = 1'b0; bus.trapCause = 4'h0;
        bus.trapValue   = 32'h0; bus.trapPc    = 32'h0;
        bus.trapReturn  = 1'b0; bus.trapReturnPrivilege = 2'b00;
        bus.readAddr    = 12'h0; bus.readEnable = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic do_write(input bit [11:0] a, input bit [31:0] d);
        next_cycle();
        bus.writeEnable = 1'b1; bus.writeAddr = a; bus.writeValue = d;
    endtask

    task automatic do_trap(input bit [3:0] cause, input bit intr, input bit [31:0] pc);
        next_cycle();
        bus.trapValid = 1'b1; bus.trapCause = cause; bus.trapInterrupt = intr;
        bus.trapPc = pc; bus.trapValue = 32'hBAD0_0000 | 32'(cause);
    endtask

    task automatic do_ret(input bit [1:0] rp);
        next_cycle();
        bus.trapReturn = 1'b1; bus.trapReturnPrivilege = rp;
    endtask

    bit [11:0] addrs [$] = '{12'h100, 12'h105, 12'h140, 12'h141, 12'h142, 12'h143, 12'h180,
                             12'h300, 12'h301, 12'h302, 12'h303, 12'h305, 12'h340, 12'h341,
                             12'h342, 12'h343, 12'hB00, 12'hB80, 12'hC00, 12'hC80, 12'hF14,
                             12'h7C0, 12'h104};

    initial begin
        idle_inputs();
        model_reset();
        rstN = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_priv",    32'(bus.privilege), 32'h3);
        chk("rst_npc",     bus.nextPc,         32'h8000_0000);
        chk("rst_mstatus", bus.mstatus,        32'h0);
        check_read("rst_cycle", 12'hC00, 1'b1);
        chk_outputs("rst");
        rstN = 1'b1;

        do_write(12'h340, 32'hDEAD_BEEF);
        bus.readAddr = 12'h340; bus.readEnable = 1'b1; #1;
        chk("wr_same_cycle", bus.readValue, 32'h0);
        next_cycle();
        bus.readAddr = 12'h340; bus.readEnable = 1'b1; #1;
        chk("wr_next_cycle", bus.readValue, 32'hDEAD_BEEF);

        do_write(12'h302, 32'h0000_0100);
        do_write(12'h105, 32'h8000_1000);
        do_write(12'h300, 32'h0);
        do_write(12'h341, 32'h400);
        do_ret(2'b11);
        next_cycle();
        chk("to_user_priv", 32'(bus.privilege), 32'h0);
        chk("to_user_npc",  bus.nextPc,         32'h400);

        do_trap(4'd8, 1'b0, 32'h100);
        next_cycle();
        chk("dtrap_priv", 32'(bus.privilege), 32'h1);
        chk("dtrap_npc",  bus.nextPc,         32'h8000_1000);
        chk("dtrap_spp",  32'(bus.mstatus[8]), 32'h0);
        bus.readEnable = 1'b1; bus.readAddr = 12'h141; #1;
        chk("dtrap_sepc", bus.readValue, 32'h100);
        bus.readAddr = 12'h142; #1;
        chk("dtrap_scause", bus.readValue, 32'h8);
        chk_outputs("dtrap");

        do_trap(4'd2, 1'b0, 32'h180);
        next_cycle();
        chk("mtrap_priv", 32'(bus.privilege),       32'h3);
        chk("mtrap_mpp",  32'(bus.mstatus[12:11]),  32'h1);
        do_write(12'h341, 32'h200);
        do_write(12'h300, 32'h0000_0880);
        do_ret(2'b11);
        next_cycle();
        chk("mret_priv", 32'(bus.privilege),      32'h1);
        chk("mret_mie",  32'(bus.mstatus[3]),     32'h1);
        chk("mret_mpp",  32'(bus.mstatus[12:11]), 32'h0);
        chk("mret_npc",  bus.nextPc,              32'h200);

        bus.readAddr = 12'h300; bus.readEnable = 1'b1; #1;
        chk("ill_flag", 32'(bus.readIllegal), 32'h1);
        chk("ill_val",  bus.readValue,        32'h0);
        bus.readEnable = 1'b0; #1;
        chk("ill_noen", 32'(bus.readIllegal), 32'h0);

        do_trap(4'd3, 1'b0, 32'h280);
        do_write(12'hB80, 32'h0);
        do_write(12'hB00, 32'hFFFF_FFFF);
        next_cycle();
        bus.readEnable = 1'b1; bus.readAddr = 12'hB00; #1;
        chk("carry_hold", bus.readValue, 32'hFFFF_FFFF);
        next_cycle();
        bus.readEnable = 1'b1; bus.readAddr = 12'hB00; #1;
        chk("carry_lo", bus.readValue, 32'h0);
        bus.readAddr = 12'hB80; #1;
        chk("carry_hi", bus.readValue, 32'h1);

        do_trap(4'd5, 1'b0, 32'h300);
        bus.writeEnable = 1'b1; bus.writeAddr = 12'h340; bus.writeValue = 32'h1234;
        next_cycle();
        bus.readEnable = 1'b1; bus.readAddr = 12'h340; #1;
        chk("coll_mscratch", bus.readValue, 32'hDEAD_BEEF);
        bus.readAddr = 12'h342; #1;
        chk("coll_mcause", bus.readValue, 32'h5);
        chk_outputs("coll");

        for (int i = 0; i < 400; i++) begin
            int op;
            next_cycle();
            chk_outputs("rnd");
            op = int'($urandom_range(0, 9));
            if (op <= 4 || op == 8) begin
                bus.writeEnable = 1'b1;
                bus.writeAddr   = addrs[$urandom_range(0, addrs.size() - 1)];
                bus.writeValue  = $urandom;
            end
            if (op == 5 || op == 6 || op == 8) begin
                bus.trapValid     = 1'b1;
                bus.trapCause     = 4'($urandom);
                bus.trapInterrupt = 1'($urandom);
                bus.trapPc        = $urandom;
                bus.trapValue     = $urandom;
            end
            if (op == 7 || op == 8) begin
                bus.trapReturn          = 1'b1;
                bus.trapReturnPrivilege = 2'($urandom);
            end
            check_read("rnd", addrs[$urandom_range(0, addrs.size() - 1)], 1'($urandom));
        end

        next_cycle();
        #2;
        rstN = 1'b0;
        #1;
        chk("arst_priv",    32'(bus.privilege), 32'h3);
        chk("arst_npc",     bus.nextPc,         32'h8000_0000);
        chk("arst_mstatus", bus.mstatus,        32'h0);
        bus.readEnable = 1'b1; bus.readAddr = 12'hC00; #1;
        chk("arst_cycle", bus.readValue, 32'h0);
        next_cycle();
        rstN = 1'b1;
        next_cycle();
        chk_outputs("post_rst");
        check_read("post_rst", 12'hC00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
